bcd_time_of_day_up: RTL and testbench

//  Up-counting HH:MM:SS time-of-day core for the clock display path. Stores six BCD digits,

---
 rtl/bcd_time_of_day_up_if.sv | 42 ++++
 rtl/bcd_time_of_day_up.sv | 161 ++++++++++++++++
 tb/tb_bcd_time_of_day_up.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bcd_time_of_day_up_if.sv
// Time-of-day core bus: load/tick controls, BCD load digits,
// current time digits and one-cycle status pulses.
interface bcd_time_of_day_up_if;
  logic       tick;
  logic       load;
  logic [3:0] hh_t_in;
  logic [3:0] hh_o_in;
  logic [3:0] mm_t_in;
  logic [3:0] mm_o_in;
  logic [3:0] ss_t_in;
  logic [3:0] ss_o_in;
  logic       pm_in;
  logic [3:0] hh_t;
  logic [3:0] hh_o;
  logic [3:0] mm_t;
  logic [3:0] mm_o;
  logic [3:0] ss_t;
  logic [3:0] ss_o;
  logic       pm;
  logic       min_carry;
  logic       hr_carry;
  logic       day_carry;
  logic       load_err;

  modport master (
    output tick, load,
    output hh_t_in, hh_o_in, mm_t_in,
    output mm_o_in, ss_t_in, ss_o_in, pm_in,
    input  hh_t, hh_o, mm_t, mm_o, ss_t, ss_o,
    input  pm, min_carry, hr_carry,
    input  day_carry, load_err
  );

  modport slave (
    input  tick, load,
    input  hh_t_in, hh_o_in, mm_t_in,
    input  mm_o_in, ss_t_in, ss_o_in, pm_in,
    output hh_t, hh_o, mm_t, mm_o, ss_t, ss_o,
    output pm, min_carry, hr_carry,
    output day_carry, load_err
  );
endinterface

// File: rtl/bcd_time_of_day_up.sv
// HH:MM:SS BCD up-counter with validated load,
// 24h or 12h (pm flag) hour mode and rollover pulses.
module bcd_time_of_day_up #(
  parameter bit H24 = 1'b1
) (
  input logic clk,
  input logic rst,
  bcd_time_of_day_up_if.slave bus
);

  logic [3:0] hh_t, hh_o, mm_t, mm_o, ss_t, ss_o;
  logic       pm;
  logic       min_carry, hr_carry, day_carry, load_err;

  logic [3:0] n_hh_t, n_hh_o, n_mm_t, n_mm_o;
  logic [3:0] n_ss_t, n_ss_o;
  logic       n_pm, n_mc, n_hc, n_dc;
  logic       ok_ms, ok_hr, ok;

  // Validate the load digits; hour range depends on mode
  always_comb begin
    ok_ms = (bus.mm_t_in <= 4'd5) && (bus.mm_o_in <= 4'd9) &&
            (bus.ss_t_in <= 4'd5) && (bus.ss_o_in <= 4'd9);
    ok_hr = 1'b0;
    if (H24) begin
      ok_hr = ((bus.hh_t_in <= 4'd1) && (bus.hh_o_in <= 4'd9)) ||
              ((bus.hh_t_in == 4'd2) && (bus.hh_o_in <= 4'd3));
    end else begin
      ok_hr = ((bus.hh_t_in == 4'd0) && (bus.hh_o_in >= 4'd1) &&
               (bus.hh_o_in <= 4'd9)) ||
              ((bus.hh_t_in == 4'd1) && (bus.hh_o_in <= 4'd2));
    end
    ok = ok_ms && ok_hr;
  end

  // Next time on a tick: digit-by-digit cascade
  always_comb begin
    n_hh_t = hh_t;
    n_hh_o = hh_o;
    n_mm_t = mm_t;
    n_mm_o = mm_o;
    n_ss_t = ss_t;
    n_ss_o = ss_o;
    n_pm   = pm;
    n_mc   = 1'b0;
    n_hc   = 1'b0;
    n_dc   = 1'b0;
    if (ss_o != 4'd9) begin
      n_ss_o = ss_o + 4'd1;
    end else begin
      n_ss_o = 4'd0;
      if (ss_t != 4'd5) begin
        n_ss_t = ss_t + 4'd1;
      end else begin
        n_ss_t = 4'd0;
        n_mc   = 1'b1;
        if (mm_o != 4'd9) begin
          n_mm_o = mm_o + 4'd1;
        end else begin
          n_mm_o = 4'd0;
          if (mm_t != 4'd5) begin
            n_mm_t = mm_t + 4'd1;
          end else begin
            n_mm_t = 4'd0;
            n_hc   = 1'b1;
            if (H24) begin
              unique case (1'b1)
                (hh_t == 4'd2 && hh_o == 4'd3): begin
                  n_hh_t = 4'd0;
                  n_hh_o = 4'd0;
                  n_dc   = 1'b1;
                end
                (hh_o == 4'd9): begin
                  n_hh_t = hh_t + 4'd1;
                  n_hh_o = 4'd0;
                end
                default: n_hh_o = hh_o + 4'd1;
              endcase
            end else begin
              unique case (1'b1)
                (hh_t == 4'd1 && hh_o == 4'd2): begin
                  n_hh_t = 4'd0;
                  n_hh_o = 4'd1;
                end
                (hh_t == 4'd1 && hh_o == 4'd1): begin
                  n_hh_o = 4'd2;
                  n_pm   = ~pm;
                  n_dc   = pm;
                end
                (hh_o == 4'd9): begin
                  n_hh_t = hh_t + 4'd1;
                  n_hh_o = 4'd0;
                end
                default: n_hh_o = hh_o + 4'd1;
              endcase
            end
          end
        end
      end
    end
  end

  // Time state and pulses: rst > load > tick
  always_ff @(posedge clk) begin
    if (rst) begin
      hh_t      <= H24 ? 4'd0 : 4'd1;
      hh_o      <= H24 ? 4'd0 : 4'd2;
      mm_t      <= 4'd0;
      mm_o      <= 4'd0;
      ss_t      <= 4'd0;
      ss_o      <= 4'd0;
      pm        <= 1'b0;
      min_carry <= 1'b0;
      hr_carry  <= 1'b0;
      day_carry <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      min_carry <= 1'b0;
      hr_carry  <= 1'b0;
      day_carry <= 1'b0;
      load_err  <= 1'b0;
      if (bus.load) begin
        if (ok) begin
          hh_t <= bus.hh_t_in;
          hh_o <= bus.hh_o_in;
          mm_t <= bus.mm_t_in;
          mm_o <= bus.mm_o_in;
          ss_t <= bus.ss_t_in;
          ss_o <= bus.ss_o_in;
          pm   <= H24 ? 1'b0 : bus.pm_in;
        end else begin
          load_err <= 1'b1;
        end
      end else if (bus.tick) begin
        hh_t      <= n_hh_t;
        hh_o      <= n_hh_o;
        mm_t      <= n_mm_t;
        mm_o      <= n_mm_o;
        ss_t      <= n_ss_t;
        ss_o      <= n_ss_o;
        pm        <= n_pm;
        min_carry <= n_mc;
        hr_carry  <= n_hc;
        day_carry <= n_dc;
      end
    end
  end

  assign bus.hh_t      = hh_t;
  assign bus.hh_o      = hh_o;
  assign bus.mm_t      = mm_t;
  assign bus.mm_o      = mm_o;
  assign bus.ss_t      = ss_t;
  assign bus.ss_o      = ss_o;
  assign bus.pm        = pm;
  assign bus.min_carry = min_carry;
  assign bus.hr_carry  = hr_carry;
  assign bus.day_carry = day_carry;
  assign bus.load_err  = load_err;

endmodule

// File: tb/tb_bcd_time_of_day_up.sv
// Scoreboard bench for bcd_time_of_day_up in 24h and 12h modes.
// Expected word: {hh,mm,ss BCD, pm, min_c, hr_c, day_c, load_err}.
module tb_bcd_time_of_day_up;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  bcd_time_of_day_up_if b24 ();
  bcd_time_of_day_up_if b12 ();

  bcd_time_of_day_up #(.H24(1'b1)) u24 (
    .clk (clk),
    .rst (rst),
    .bus (b24.slave)
  );

  bcd_time_of_day_up #(.H24(1'b0)) u12 (
    .clk (clk),
    .rst (rst),
    .bus (b12.slave)
  );

  typedef struct {
    bit          w;
    string       name;
    logic [28:0] exp;
    int          tgt;
  } item_t;

  item_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [28:0] act(input bit w);
    if (w)
      return {b24.hh_t, b24.hh_o, b24.mm_t, b24.mm_o,
              b24.ss_t, b24.ss_o, b24.pm, b24.min_carry,
              b24.hr_carry, b24.day_carry, b24.load_err};
    else
      return {b12.hh_t, b12.hh_o, b12.mm_t, b12.mm_o,
              b12.ss_t, b12.ss_o, b12.pm, b12.min_carry,
              b12.hr_carry, b12.day_carry, b12.load_err};
  endfunction

  // Monitor: compare every expectation due this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tgt == cyc) begin
      item_t it;
      logic [28:0] a;
      it = q.pop_front();
      a  = act(it.w);
      compared = compared + 1;
      if (a !== it.exp) begin
        mismatched = mismatched + 1;
        $display("FAIL %s (%s): got %h required %h",
                 it.name, it.w ? "h24" : "h12", a, it.exp);
      end
    end
  end

  task automatic idle_all();
    b24.tick = 1'b0; b24.load = 1'b0;
    b12.tick = 1'b0; b12.load = 1'b0;
  endtask

  task automatic push(input bit w, input string n,
                      input logic [23:0] t, input logic [4:0] f);
    item_t it;
    it.w    = w;
    it.name = n;
    it.exp  = {t, f};
    it.tgt  = cyc + 1;
    q.push_back(it);
  endtask

  task automatic step(input bit w, input bit r, input bit tk,
                      input bit ld, input logic [23:0] tin,
                      input bit p, input string n,
                      input logic [23:0] t, input logic [4:0] f);
    idle_all();
    rst = r;
    if (w) begin
      b24.tick = tk; b24.load = ld;
      {b24.hh_t_in, b24.hh_o_in, b24.mm_t_in,
       b24.mm_o_in, b24.ss_t_in, b24.ss_o_in} = tin;
      b24.pm_in = p;
    end else begin
      b12.tick = tk; b12.load = ld;
      {b12.hh_t_in, b12.hh_o_in, b12.mm_t_in,
       b12.mm_o_in, b12.ss_t_in, b12.ss_o_in} = tin;
      b12.pm_in = p;
    end
    push(w, n, t, f);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    {b24.hh_t_in, b24.hh_o_in, b24.mm_t_in,
     b24.mm_o_in, b24.ss_t_in, b24.ss_o_in} = 24'h0;
    {b12.hh_t_in, b12.hh_o_in, b12.mm_t_in,
     b12.mm_o_in, b12.ss_t_in, b12.ss_o_in} = 24'h0;
    b24.pm_in = 1'b0;
    b12.pm_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(1'b1, "rst", 24'h000000, 5'b00000);
    push(1'b0, "rst", 24'h120000, 5'b00000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 24h mode
    step(1,0,0,1,24'h000058,0,"ld58",  24'h000058,5'b00000);
    step(1,0,1,0,24'h0,     0,"t59",   24'h000059,5'b00000);
    step(1,0,1,0,24'h0,     0,"t100",  24'h000100,5'b01000);
    step(1,0,0,0,24'h0,     0,"hold",  24'h000100,5'b00000);
    step(1,0,0,1,24'h235959,0,"ld2359",24'h235959,5'b00000);
    step(1,0,1,0,24'h0,     0,"day",   24'h000000,5'b01110);
    step(1,0,0,0,24'h0,     0,"dayoff",24'h000000,5'b00000);
    step(1,0,0,1,24'h095959,1,"ld0959",24'h095959,5'b00000);
    step(1,0,1,0,24'h0,     0,"hr10",  24'h100000,5'b01100);
    step(1,0,0,1,24'h240000,0,"err24", 24'h100000,5'b00001);
    step(1,0,0,0,24'h0,     0,"erroff",24'h100000,5'b00000);
    step(1,0,0,1,24'h106A00,0,"err6A", 24'h100000,5'b00001);
    step(1,0,1,1,24'h102030,0,"ldtick",24'h102030,5'b00000);
    step(1,0,1,0,24'h0,     0,"t2031", 24'h102031,5'b00000);
    step(1,0,0,1,24'h123456,1,"ld1234",24'h123456,5'b00000);
    step(1,1,1,0,24'h0,     0,"rsttk", 24'h000000,5'b00000);
    step(1,0,0,1,24'h111111,0,"ld1111",24'h111111,5'b00000);
    step(1,1,0,1,24'h102030,0,"rstld", 24'h000000,5'b00000);

    // 12h mode
    step(0,0,0,1,24'h115959,0,"ld11a", 24'h115959,5'b00000);
    step(0,0,1,0,24'h0,     0,"noon",  24'h120000,5'b11100);
    step(0,0,0,1,24'h125959,1,"ld12p", 24'h125959,5'b10000);
    step(0,0,1,0,24'h0,     0,"one",   24'h010000,5'b11100);
    step(0,0,0,0,24'h0,     0,"hold12",24'h010000,5'b10000);
    step(0,0,0,1,24'h115959,1,"ld11p", 24'h115959,5'b10000);
    step(0,0,1,0,24'h0,     0,"midn",  24'h120000,5'b01110);
    step(0,0,0,1,24'h130000,0,"err13", 24'h120000,5'b00001);
    step(0,0,0,1,24'h000000,1,"err00", 24'h120000,5'b00001);
    step(0,0,0,1,24'h095959,0,"ld09",  24'h095959,5'b00000);
    step(0,0,1,0,24'h0,     0,"t10",   24'h100000,5'b01100);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d pending required 0", q.size());
      mismatched = mismatched + q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
